// File: rtl/cpu_hatch_mem_if.sv
// Fetch port and program-load byte stream between cpu_hatch_mem and its neighbours.
// The master side drives addresses and load bytes; the slave side answers with words and ready.
interface cpu_hatch_mem_if;
  logic [31:0] hatch_address;
  logic [47:0] hatch_instruction;
  logic        ld_start;
  logic        ld_end;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_ready;

  modport master (
    output hatch_address,
    output ld_start,
    output ld_end,
    output ld_valid,
    output ld_data,
    input  hatch_instruction,
    input  ld_ready
  );

  modport slave (
    input  hatch_address,
    input  ld_start,
    input  ld_end,
    input  ld_valid,
    input  ld_data,
    output hatch_instruction,
    output ld_ready
  );
endinterface

// File: rtl/cpu_hatch_mem.sv
// Instruction store for the cpu fetch port plus the byte-stream program loader
// that fills it and holds the core in reset until a load completes.
module cpu_hatch_mem #(
  parameter int          ADDR_W   = 10,
  parameter logic [47:0] OOR_WORD = 48'h0
) (
  input  logic                clk,
  input  logic                rst_b,
  cpu_hatch_mem_if.slave      bus,
  output logic                cpu_rst_b,
  output logic [ADDR_W:0]     ld_word_count,
  output logic                ld_err,
  output logic                ld_ovf
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] ADDR_ONE = 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  typedef enum logic [1:0] {RD_ZERO, RD_MEM, RD_OOR} rd_sel_t;

  state_t          state_reg, state_next;
  logic [2:0]      byte_cnt_reg, byte_cnt_next;
  logic [ADDR_W:0] wr_addr_reg, wr_addr_next;
  logic [ADDR_W:0] word_count_reg, word_count_next;
  logic [47:0]     asm_reg, asm_next;
  logic            err_reg, err_next;
  logic            ovf_reg, ovf_next;
  logic            ready_reg, ready_next;
  logic            cpu_rst_b_reg, cpu_rst_b_next;
  rd_sel_t         rd_sel_reg, rd_sel_next;

  logic            wr_en;
  logic [47:0]     wr_word;
  logic            in_range;

  logic [47:0]     mem [DEPTH];
  logic [47:0]     mem_q;

  // The write address carries one extra bit so that "full" is simply its MSB.
  always_comb begin
    state_next      = state_reg;
    byte_cnt_next   = byte_cnt_reg;
    wr_addr_next    = wr_addr_reg;
    word_count_next = word_count_reg;
    asm_next        = asm_reg;
    err_next        = err_reg;
    ovf_next        = ovf_reg;
    wr_en           = 1'b0;
    wr_word         = {asm_reg[39:0], bus.ld_data};

    case (state_reg)
      IDLE: begin
        if (bus.ld_start) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (!bus.ld_start) begin
          if (bus.ld_valid) begin
            if (wr_addr_reg[ADDR_W]) begin
              ovf_next = 1'b1;
            end else begin
              asm_next = wr_word;
              if (byte_cnt_reg == 3'd5) begin
                wr_en         = 1'b1;
                wr_addr_next  = wr_addr_reg + ADDR_ONE;
                byte_cnt_next = 3'd0;
                if (!word_count_reg[ADDR_W]) begin
                  word_count_next = word_count_reg + ADDR_ONE;
                end
              end else begin
                byte_cnt_next = byte_cnt_reg + 3'd1;
              end
            end
          end
          // The partial-word check sees the byte accepted in this same cycle.
          if (bus.ld_end) begin
            state_next = RUN;
            if (byte_cnt_next != 3'd0) begin
              err_next = 1'b1;
            end
            byte_cnt_next = 3'd0;
          end
        end
      end
      RUN: begin
        if (bus.ld_start) begin
          state_next = LOAD;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Any ld_start (including a restart while loading) opens a fresh load.
    if (bus.ld_start) begin
      state_next      = LOAD;
      byte_cnt_next   = 3'd0;
      wr_addr_next    = '0;
      word_count_next = '0;
      err_next        = 1'b0;
      ovf_next        = 1'b0;
    end
  end

  always_comb begin
    ready_next     = (state_next == LOAD);
    cpu_rst_b_next = (state_next == RUN);
    in_range       = ((bus.hatch_address >> ADDR_W) == 32'd0);
    rd_sel_next    = RD_ZERO;
    // Leaving RUN blanks the output on the same edge the core goes back into reset.
    if (state_reg == RUN && !bus.ld_start) begin
      rd_sel_next = in_range ? RD_MEM : RD_OOR;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_reg      <= IDLE;
      byte_cnt_reg   <= 3'd0;
      wr_addr_reg    <= '0;
      word_count_reg <= '0;
      asm_reg        <= '0;
      err_reg        <= 1'b0;
      ovf_reg        <= 1'b0;
      ready_reg      <= 1'b0;
      cpu_rst_b_reg  <= 1'b0;
      rd_sel_reg     <= RD_ZERO;
    end else begin
      state_reg      <= state_next;
      byte_cnt_reg   <= byte_cnt_next;
      wr_addr_reg    <= wr_addr_next;
      word_count_reg <= word_count_next;
      asm_reg        <= asm_next;
      err_reg        <= err_next;
      ovf_reg        <= ovf_next;
      ready_reg      <= ready_next;
      cpu_rst_b_reg  <= cpu_rst_b_next;
      rd_sel_reg     <= rd_sel_next;
    end
  end

  // RAM kept free of reset so it maps onto block RAM with a registered read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr_reg[ADDR_W-1:0]] <= wr_word;
    end
    mem_q <= mem[bus.hatch_address[ADDR_W-1:0]];
  end

  assign bus.hatch_instruction = (rd_sel_reg == RD_MEM) ? mem_q :
                                 (rd_sel_reg == RD_OOR) ? OOR_WORD : 48'h0;
  assign bus.ld_ready          = ready_reg;
  assign cpu_rst_b             = cpu_rst_b_reg;
  assign ld_word_count         = word_count_reg;
  assign ld_err                = err_reg;
  assign ld_ovf                = ovf_reg;

endmodule

// File: tb/tb_cpu_hatch_mem.sv
// Directed bench for cpu_hatch_mem: a 1024-word and a 4-word instance share one
// stimulus stream; a per-cycle vector table plus hand sequences for corner cases.
module tb_cpu_hatch_mem;

  logic        clk;
  logic        rst_b;
  logic        ld_start, ld_end, ld_valid;
  logic [7:0]  ld_data;
  logic [31:0] hatch_address;

  logic        crst_a, err_a, ovf_a;
  logic        crst_b, err_b, ovf_b;
  logic [10:0] wc_a;
  logic [2:0]  wc_b;

  int checks;
  int failures;

  cpu_hatch_mem_if bus_a ();
  cpu_hatch_mem_if bus_b ();

  assign bus_a.hatch_address = hatch_address;
  assign bus_a.ld_start      = ld_start;
  assign bus_a.ld_end        = ld_end;
  assign bus_a.ld_valid      = ld_valid;
  assign bus_a.ld_data       = ld_data;
  assign bus_b.hatch_address = hatch_address;
  assign bus_b.ld_start      = ld_start;
  assign bus_b.ld_end        = ld_end;
  assign bus_b.ld_valid      = ld_valid;
  assign bus_b.ld_data       = ld_data;

  cpu_hatch_mem #(.ADDR_W(10), .OOR_WORD(48'h0)) dut_a (
    .clk(clk), .rst_b(rst_b), .bus(bus_a),
    .cpu_rst_b(crst_a), .ld_word_count(wc_a), .ld_err(err_a), .ld_ovf(ovf_a)
  );

  cpu_hatch_mem #(.ADDR_W(2), .OOR_WORD(48'h0)) dut_b (
    .clk(clk), .rst_b(rst_b), .bus(bus_b),
    .cpu_rst_b(crst_b), .ld_word_count(wc_b), .ld_err(err_b), .ld_ovf(ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        en;
    logic        v;
    logic [7:0]  d;
    logic [31:0] addr;
    logic        exp_crst;
    logic        exp_rdy;
    logic [10:0] exp_wc;
    logic        exp_err;
    logic [47:0] exp_ins;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic st, input logic en, input logic v, input logic [7:0] d,
                         input logic [31:0] addr, input logic crst, input logic rdy,
                         input logic [10:0] wc, input logic err, input logic [47:0] ins);
    vec_t r;
    r.st = st; r.en = en; r.v = v; r.d = d; r.addr = addr;
    r.exp_crst = crst; r.exp_rdy = rdy; r.exp_wc = wc; r.exp_err = err; r.exp_ins = ins;
    vecs.push_back(r);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_ins(input string name, input logic [47:0] exp_a, input logic [47:0] exp_b);
    chk({"a.ins ", name}, {16'h0, bus_a.hatch_instruction}, {16'h0, exp_a});
    chk({"b.ins ", name}, {16'h0, bus_b.hatch_instruction}, {16'h0, exp_b});
  endtask

  task automatic chk_ctl(input string name, input logic crst, input logic rdy,
                         input logic [10:0] wc, input logic err);
    chk({"a.crst ", name}, {63'h0, crst_a}, {63'h0, crst});
    chk({"b.crst ", name}, {63'h0, crst_b}, {63'h0, crst});
    chk({"a.rdy ", name}, {63'h0, bus_a.ld_ready}, {63'h0, rdy});
    chk({"b.rdy ", name}, {63'h0, bus_b.ld_ready}, {63'h0, rdy});
    chk({"a.wc ", name}, {53'h0, wc_a}, {53'h0, wc});
    chk({"b.wc ", name}, {61'h0, wc_b}, {53'h0, wc});
    chk({"a.err ", name}, {63'h0, err_a}, {63'h0, err});
    chk({"b.err ", name}, {63'h0, err_b}, {63'h0, err});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    ld_valid = 1'b1;
    ld_data  = d;
    cyc();
    ld_valid = 1'b0;
  endtask

  task automatic pulse_start();
    ld_start = 1'b1;
    cyc();
    ld_start = 1'b0;
  endtask

  task automatic pulse_end();
    ld_end = 1'b1;
    cyc();
    ld_end = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] addr);
    hatch_address = addr;
    cyc();
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_b = 1'b0; ld_start = 1'b0; ld_end = 1'b0; ld_valid = 1'b0;
    ld_data = 8'h0; hatch_address = 32'h0;

    // Test 1 as a per-cycle table: start, 12 bytes 01..0C, end, fetches.
    add_vec(1, 0, 0, 8'h00, 32'h0, 0, 1, 11'd0, 0, 48'h0);
    for (int i = 1; i <= 12; i++)
      add_vec(0, 0, 1, 8'(i), 32'h0, 0, 1, 11'(i / 6), 0, 48'h0);
    add_vec(0, 1, 0, 8'h00, 32'h0, 1, 0, 11'd2, 0, 48'h0);
    add_vec(0, 0, 0, 8'h00, 32'h0, 1, 0, 11'd2, 0, 48'h010203040506);
    add_vec(0, 0, 0, 8'h00, 32'h1, 1, 0, 11'd2, 0, 48'h0708090A0B0C);
    add_vec(0, 0, 0, 8'h00, 32'h0, 1, 0, 11'd2, 0, 48'h010203040506);

    // Reset state
    repeat (3) cyc();
    chk_ctl("reset", 0, 0, 11'd0, 0);
    chk_ins("reset", 48'h0, 48'h0);
    chk("a.ovf reset", {63'h0, ovf_a}, 64'h0);
    chk("b.ovf reset", {63'h0, ovf_b}, 64'h0);
    rst_b = 1'b1;
    cyc();

    foreach (vecs[i]) begin
      ld_start = vecs[i].st; ld_end = vecs[i].en; ld_valid = vecs[i].v;
      ld_data = vecs[i].d; hatch_address = vecs[i].addr;
      cyc();
      chk_ctl($sformatf("vec%0d", i), vecs[i].exp_crst, vecs[i].exp_rdy, vecs[i].exp_wc, vecs[i].exp_err);
      chk_ins($sformatf("vec%0d", i), vecs[i].exp_ins, vecs[i].exp_ins);
    end
    ld_start = 1'b0; ld_end = 1'b0; ld_valid = 1'b0; hatch_address = 32'h0;

    // Test 2: 7 bytes then end -> partial word dropped, ld_err set
    pulse_start();
    for (int i = 0; i < 7; i++) send_byte(8'h11 + 8'(i));
    pulse_end();
    chk_ctl("partial", 1, 0, 11'd1, 1);
    fetch(32'h1);
    chk_ins("partial addr1", 48'h0708090A0B0C, 48'h0708090A0B0C);
    fetch(32'h0);
    chk_ins("partial addr0", 48'h111213141516, 48'h111213141516);

    // Test 4a: sixth byte together with ld_end completes the word
    pulse_start();
    for (int i = 0; i < 5; i++) send_byte(8'h21 + 8'(i));
    ld_valid = 1'b1; ld_data = 8'h26; ld_end = 1'b1;
    cyc();
    ld_valid = 1'b0; ld_end = 1'b0;
    chk_ctl("byte6+end", 1, 0, 11'd1, 0);
    fetch(32'h0);
    chk_ins("byte6+end", 48'h212223242526, 48'h212223242526);

    // Test 4b: ld_start and ld_end together in LOAD -> restart wins
    pulse_start();
    for (int i = 0; i < 9; i++) send_byte(8'h27 + 8'(i));
    ld_start = 1'b1; ld_end = 1'b1;
    cyc();
    ld_start = 1'b0; ld_end = 1'b0;
    chk_ctl("start+end", 0, 1, 11'd0, 0);
    for (int i = 0; i < 6; i++) send_byte(8'h31 + 8'(i));
    pulse_end();
    chk_ctl("after restart", 1, 0, 11'd1, 0);
    fetch(32'h0);
    chk_ins("after restart", 48'h313233343536, 48'h313233343536);

    // Test 5: ld_start in RUN blanks output and re-asserts core reset next cycle
    hatch_address = 32'h0;
    pulse_start();
    chk_ctl("run->load", 0, 1, 11'd0, 0);
    chk_ins("run->load", 48'h0, 48'h0);
    for (int i = 0; i < 6; i++) send_byte(8'hAA + 8'(i * 17));
    pulse_end();
    fetch(32'h0);
    chk_ins("reload", 48'hAABBCCDDEEFF, 48'hAABBCCDDEEFF);

    // Test 3: 30 bytes; the 4-word instance fills and flags overflow
    pulse_start();
    for (int i = 0; i < 30; i++) send_byte(8'h40 + 8'(i));
    chk("a.rdy stream", {63'h0, bus_a.ld_ready}, 64'h1);
    chk("b.rdy full", {63'h0, bus_b.ld_ready}, 64'h1);
    chk("a.wc stream", {53'h0, wc_a}, 64'd5);
    chk("b.wc full", {61'h0, wc_b}, 64'd4);
    chk("a.ovf stream", {63'h0, ovf_a}, 64'h0);
    chk("b.ovf full", {63'h0, ovf_b}, 64'h1);
    pulse_end();
    chk("a.err full", {63'h0, err_a}, 64'h0);
    chk("b.err full", {63'h0, err_b}, 64'h0);
    chk("b.crst full", {63'h0, crst_b}, 64'h1);
    fetch(32'h0); chk_ins("ovf w0", 48'h404142434445, 48'h404142434445);
    fetch(32'h1); chk_ins("ovf w1", 48'h464748494A4B, 48'h464748494A4B);
    fetch(32'h2); chk_ins("ovf w2", 48'h4C4D4E4F5051, 48'h4C4D4E4F5051);
    fetch(32'h3); chk_ins("ovf w3", 48'h525354555657, 48'h525354555657);
    fetch(32'h4); chk_ins("ovf w4", 48'h58595A5B5C5D, 48'h0);
    fetch(32'h5);
    chk("b.ins addr5", {16'h0, bus_b.hatch_instruction}, 64'h0);
    fetch(32'h8000_0000); chk_ins("addr 80000000", 48'h0, 48'h0);
    fetch(32'h8000_0001); chk_ins("addr 80000001", 48'h0, 48'h0);
    hatch_address = 32'h0;

    // Test 6: async reset mid-word in LOAD
    pulse_start();
    for (int i = 0; i < 9; i++) send_byte(8'h51 + 8'(i));
    rst_b = 1'b0;
    #1;
    chk_ctl("async rst", 0, 0, 11'd0, 0);
    chk_ins("async rst", 48'h0, 48'h0);
    cyc(); cyc();
    rst_b = 1'b1;
    for (int i = 0; i < 6; i++) send_byte(8'h61 + 8'(i));
    chk_ctl("idle bytes", 0, 0, 11'd0, 0);
    pulse_end();
    chk_ctl("idle end", 0, 0, 11'd0, 0);
    pulse_start();
    pulse_end();
    chk_ctl("empty load", 1, 0, 11'd0, 0);
    fetch(32'h0);
    chk_ins("kept word", 48'h515253545556, 48'h515253545556);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
